// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main controller: field widths,
// opcode constants, FSM state encodings and the encodings of the multi-bit
// datapath select fields.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int STATE_W  = 4;

  // Instr[31:26] values that the controller recognises
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;

  // FSM states; encodings 14 and 15 are unused
  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_BNE     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ORIEX   = 4'd11,
    S_IMMWB   = 4'd12,
    S_JUMP    = 4'd13
  } state_e;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMX4 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_main_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_main_control_if
// Bundle between the main controller and the datapath.
//   Opcode_i, Zero_i          : datapath -> controller (instruction opcode, ALU zero)
//   IorD_o .. Mem_to_Reg_o    : controller -> datapath enables and mux selects
//   State_o                   : controller -> debug view of the current state
// modport master is the controller side, modport slave the datapath side.
// -----------------------------------------------------------------------------
interface multicycle_main_control_if;
  import mips_ctrl_pkg::*;

  logic [OPCODE_W-1:0] Opcode_i;
  logic                Zero_i;
  logic                IorD_o;
  logic                Mem_Write_o;
  logic                IR_Write_o;
  logic                PC_En_o;
  logic [1:0]          PC_Src_o;
  logic [1:0]          ALU_Op_o;
  logic                ALU_Src_A_o;
  logic [1:0]          ALU_Src_B_o;
  logic                Ext_Zero_o;
  logic                Reg_Write_o;
  logic                Reg_Dst_o;
  logic                Mem_to_Reg_o;
  logic [STATE_W-1:0]  State_o;

  modport master (
    input  Opcode_i, Zero_i,
    output IorD_o, Mem_Write_o, IR_Write_o, PC_En_o, PC_Src_o, ALU_Op_o,
           ALU_Src_A_o, ALU_Src_B_o, Ext_Zero_o, Reg_Write_o, Reg_Dst_o,
           Mem_to_Reg_o, State_o
  );

  modport slave (
    output Opcode_i, Zero_i,
    input  IorD_o, Mem_Write_o, IR_Write_o, PC_En_o, PC_Src_o, ALU_Op_o,
           ALU_Src_A_o, ALU_Src_B_o, Ext_Zero_o, Reg_Write_o, Reg_Dst_o,
           Mem_to_Reg_o, State_o
  );

endinterface

// File: rtl/main_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// main_ctrl_decoder
// Purely combinational Moore output decode of the main controller.
//   state_i        : current FSM state
//   zero_i         : ALU zero flag, used only to qualify PC_En in branch states
//   *_o            : datapath enables and mux selects for that state
// Any state without an entry, including the unused encodings, drives all 0.
// -----------------------------------------------------------------------------
module main_ctrl_decoder
  import mips_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic       zero_i,
  output logic       iord_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       pc_en_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] alu_op_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       ext_zero_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o
);

  // Control output decode from the current state
  always_comb begin
    iord_o       = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    pc_en_o      = 1'b0;
    pc_src_o     = PCSRC_ALU;
    alu_op_o     = ALUOP_ADD;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_REG;
    ext_zero_o   = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    case (state_i)
      S_FETCH: begin
        // PC + 4 goes straight back into the PC while the IR loads
        ir_write_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        pc_en_o     = 1'b1;
      end
      S_DECODE: begin
        // Speculative branch target PC + (imm << 2) lands in ALUOut
        alu_src_b_o = SRCB_IMMX4;
      end
      S_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEMRD: begin
        iord_o = 1'b1;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEMWR: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_BEQ: begin
        // Compare A - B; the target computed in DECODE is taken from ALUOut
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_SUB;
        pc_src_o    = PCSRC_ALUOUT;
        pc_en_o     = zero_i;
      end
      S_BNE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_SUB;
        pc_src_o    = PCSRC_ALUOUT;
        pc_en_o     = ~zero_i;
      end
      S_ADDIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_ORIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_OR;
        ext_zero_o  = 1'b1;
      end
      S_IMMWB: begin
        reg_write_o = 1'b1;
      end
      S_JUMP: begin
        pc_src_o = PCSRC_JUMP;
        pc_en_o  = 1'b1;
      end
      default: begin
        iord_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// -----------------------------------------------------------------------------
// multicycle_main_control
// Main control FSM of the multicycle MIPS datapath. Holds the state register
// and next-state logic; output decode lives in main_ctrl_decoder.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, forces FETCH
//   bus   : controller side of the controller/datapath bundle
// Because outputs decode from the state register, asserting reset drops any
// in-flight write enable immediately.
// -----------------------------------------------------------------------------
module multicycle_main_control
  import mips_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  multicycle_main_control_if.master   bus
);

  state_e state_q;
  state_e state_d;

  logic       iord_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       pc_en_s;
  logic [1:0] pc_src_s;
  logic [1:0] alu_op_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic       ext_zero_s;
  logic       reg_write_s;
  logic       reg_dst_s;
  logic       mem_to_reg_s;

  // State register with asynchronous return to FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the opcode only matters in DECODE and MEMADR
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode_i)
          OP_LW,
          OP_SW:    state_d = S_MEMADR;
          OP_RTYPE: state_d = S_EXECUTE;
          OP_BEQ:   state_d = S_BEQ;
          OP_BNE:   state_d = S_BNE;
          OP_ADDI:  state_d = S_ADDIEX;
          OP_ORI:   state_d = S_ORIEX;
          OP_J:     state_d = S_JUMP;
          // Unknown opcodes retire as a NOP
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.Opcode_i == OP_LW) begin
          state_d = S_MEMRD;
        end else if (bus.Opcode_i == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_IMMWB;
      S_ORIEX:   state_d = S_IMMWB;
      // Write-back, store, branch, jump and unused encodings all end here
      default:   state_d = S_FETCH;
    endcase
  end

  main_ctrl_decoder u_decoder (
    .state_i      (state_q),
    .zero_i       (bus.Zero_i),
    .iord_o       (iord_s),
    .mem_write_o  (mem_write_s),
    .ir_write_o   (ir_write_s),
    .pc_en_o      (pc_en_s),
    .pc_src_o     (pc_src_s),
    .alu_op_o     (alu_op_s),
    .alu_src_a_o  (alu_src_a_s),
    .alu_src_b_o  (alu_src_b_s),
    .ext_zero_o   (ext_zero_s),
    .reg_write_o  (reg_write_s),
    .reg_dst_o    (reg_dst_s),
    .mem_to_reg_o (mem_to_reg_s)
  );

  assign bus.IorD_o       = iord_s;
  assign bus.Mem_Write_o  = mem_write_s;
  assign bus.IR_Write_o   = ir_write_s;
  assign bus.PC_En_o      = pc_en_s;
  assign bus.PC_Src_o     = pc_src_s;
  assign bus.ALU_Op_o     = alu_op_s;
  assign bus.ALU_Src_A_o  = alu_src_a_s;
  assign bus.ALU_Src_B_o  = alu_src_b_s;
  assign bus.Ext_Zero_o   = ext_zero_s;
  assign bus.Reg_Write_o  = reg_write_s;
  assign bus.Reg_Dst_o    = reg_dst_s;
  assign bus.Mem_to_Reg_o = mem_to_reg_s;
  assign bus.State_o      = state_q;

endmodule
